// File: rtl/cuca_pkg.sv
// rtl/cuca_pkg.sv - shared ALU op, command and sequencer state types
package cuca_pkg;

    localparam int BITW = 8;

    typedef enum logic [2:0] {
        ALU_NOP      = 3'd0,
        ALU_WRITE_R0 = 3'd1,
        ALU_WRITE_R1 = 3'd2,
        ALU_ADD      = 3'd3,
        ALU_SUB      = 3'd4,
        ALU_INC      = 3'd5,
        ALU_READ_R0  = 3'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        CMD_ADD  = 2'd0,
        CMD_SUB  = 2'd1,
        CMD_INC  = 2'd2,
        CMD_PASS = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_EXEC = 3'd3,
        ST_CAPT = 3'd4,
        ST_RESP = 3'd5
    } seq_state_t;

    // ALU op that produces the command's result on the bus
    function automatic alu_op_t result_op(input cmd_t cmd);
        case (cmd)
            CMD_ADD:  return ALU_ADD;
            CMD_SUB:  return ALU_SUB;
            CMD_INC:  return ALU_INC;
            default:  return ALU_READ_R0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with last-served pointer
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_q;

    // Single requester wins outright; on a tie the one not served last wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        grant_id = grant[1];
    end

    // Pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/tri_buf.sv
// rtl/tri_buf.sv - tri-state driver onto a shared bus
module tri_buf #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output wire  [WIDTH-1:0] y
);

    assign y = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences ALU micro-ops for two requesters
module alu_sequencer
    import cuca_pkg::*;
#(
    parameter int WIDTH = BITW
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][1:0]       req_cmd,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  busy,
    output alu_op_t               alu_op,
    inout  wire  [WIDTH-1:0]      bus
);

    seq_state_t       state, state_n;
    cmd_t             cmd_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic [1:0]       grant;
    logic             grant_id;
    logic             accept;
    cmd_t             sel_cmd;
    logic             drv_en;
    logic [WIDTH-1:0] drv_data;

    rr_arb2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .req      (req_valid),
        .update   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready  = (state == ST_IDLE) ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign sel_cmd    = cmd_t'(req_cmd[grant_id]);
    assign resp_valid = (state == ST_RESP);
    assign resp_id    = id_q;
    assign busy       = (state != ST_IDLE);

    // Only WR0/WR1 drive the bus; the ALU owns it during EXEC/CAPT
    tri_buf #(.WIDTH(WIDTH)) u_tri (
        .d  (drv_data),
        .en (drv_en),
        .y  (bus)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus Moore-decoded ALU op and bus drive
    always_comb begin
        state_n  = state;
        alu_op   = ALU_NOP;
        drv_en   = 1'b0;
        drv_data = a_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = (sel_cmd == CMD_INC) ? ST_WR1 : ST_WR0;
                end
            end
            ST_WR0: begin
                alu_op   = ALU_WRITE_R0;
                drv_en   = 1'b1;
                drv_data = a_q;
                state_n  = (cmd_q == CMD_PASS) ? ST_EXEC : ST_WR1;
            end
            ST_WR1: begin
                alu_op   = ALU_WRITE_R1;
                drv_en   = 1'b1;
                drv_data = b_q;
                state_n  = ST_EXEC;
            end
            ST_EXEC: begin
                alu_op  = result_op(cmd_q);
                state_n = ST_CAPT;
            end
            ST_CAPT: begin
                alu_op  = result_op(cmd_q);
                state_n = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Latch the accepted command and capture the ALU result off the bus
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q     <= CMD_ADD;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                cmd_q <= sel_cmd;
                a_q   <= req_a[grant_id];
                b_q   <= req_b[grant_id];
                id_q  <= grant_id;
            end
            if (state == ST_CAPT) begin
                resp_data <= bus;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;
    import cuca_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][1:0] req_cmd;
    logic [1:0][7:0] req_a;
    logic [1:0][7:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_id;
    logic [7:0]      resp_data;
    logic            busy;
    alu_op_t         alu_op;
    wire  [7:0]      bus;

    int errors = 0;
    int checks = 0;

    logic [7:0] r0, r1, alu_res;
    logic       alu_drv;

    always #5 clock = ~clock;

    alu_sequencer #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_op     (alu_op),
        .bus        (bus)
    );

    // Two-register ALU environment
    always @(posedge clock) begin
        if (alu_op == ALU_WRITE_R0) r0 <= bus;
        if (alu_op == ALU_WRITE_R1) r1 <= bus;
    end

    always_comb begin
        alu_drv = 1'b1;
        alu_res = 8'h00;
        case (alu_op)
            ALU_ADD:     alu_res = r0 + r1;
            ALU_SUB:     alu_res = r0 - r1;
            ALU_INC:     alu_res = r1 + 8'h01;
            ALU_READ_R0: alu_res = r0;
            default:     alu_drv = 1'b0;
        endcase
    end

    assign bus = alu_drv ? alu_res : 8'hzz;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Issues one command and runs until RESP; collects observations only
    task automatic do_cmd(input int id, input cmd_t cmd, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [17:0] seq);
        int n;
        seq = '0;
        lat = 0;
        req_cmd[id]   = cmd;
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!req_ready[id]) begin
            errors++;
            $display("FAIL grant_timeout: req_ready=%b required bit %0d", req_ready, id);
            req_valid[id] = 1'b0;
            return;
        end
        step();
        req_valid[id] = 1'b0;
        seq = {seq[14:0], alu_op};
        while (!resp_valid && lat < 10) begin
            step();
            lat++;
            seq = {seq[14:0], alu_op};
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_cmd    = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        step();
        step();
        checks++;
        if ({busy, resp_valid, resp_id, resp_data, req_ready} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rv=%b id=%b data=%h rdy=%b required all 0",
                     busy, resp_valid, resp_id, resp_data, req_ready);
        end
        checks++;
        if (alu_op !== ALU_NOP) begin
            errors++;
            $display("FAIL reset_op: alu_op=%0d required %0d", alu_op, ALU_NOP);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_add;
        int lat;
        logic [17:0] seq;
        do_cmd(0, CMD_ADD, 8'h25, 8'h13, lat, seq);
        checks++;
        if (seq[14:0] !== {ALU_WRITE_R0, ALU_WRITE_R1, ALU_ADD, ALU_ADD, ALU_NOP}) begin
            errors++;
            $display("FAIL add_seq: got %h required %h", seq[14:0],
                     {ALU_WRITE_R0, ALU_WRITE_R1, ALU_ADD, ALU_ADD, ALU_NOP});
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d required 4", lat); end
        checks++;
        if (resp_data !== 8'h38 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL add_result: data=%h id=%b required 38 id 0", resp_data, resp_id);
        end
        step();
    endtask

    task automatic test_sub_wrap;
        int lat;
        logic [17:0] seq;
        do_cmd(1, CMD_SUB, 8'h05, 8'h07, lat, seq);
        checks++;
        if (resp_data !== 8'hFE || resp_id !== 1'b1 || lat !== 4) begin
            errors++;
            $display("FAIL sub_result: data=%h id=%b lat=%0d required FE id 1 lat 4", resp_data, resp_id, lat);
        end
        step();
        do_cmd(0, CMD_ADD, 8'hFF, 8'h02, lat, seq);
        checks++;
        if (resp_data !== 8'h01 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: data=%h id=%b required 01 id 0", resp_data, resp_id);
        end
        step();
    endtask

    task automatic test_inc_pass;
        int lat;
        logic [17:0] seq;
        do_cmd(0, CMD_INC, 8'h77, 8'hFF, lat, seq);
        checks++;
        if (seq[11:0] !== {ALU_WRITE_R1, ALU_INC, ALU_INC, ALU_NOP} || lat !== 3) begin
            errors++;
            $display("FAIL inc_seq: seq=%h lat=%0d required %h lat 3", seq[11:0], lat,
                     {ALU_WRITE_R1, ALU_INC, ALU_INC, ALU_NOP});
        end
        checks++;
        if (resp_data !== 8'h00) begin errors++; $display("FAIL inc_result: got %h required 00", resp_data); end
        step();
        do_cmd(1, CMD_PASS, 8'hA5, 8'h5A, lat, seq);
        checks++;
        if (seq[11:0] !== {ALU_WRITE_R0, ALU_READ_R0, ALU_READ_R0, ALU_NOP} || lat !== 3) begin
            errors++;
            $display("FAIL pass_seq: seq=%h lat=%0d required %h lat 3", seq[11:0], lat,
                     {ALU_WRITE_R0, ALU_READ_R0, ALU_READ_R0, ALU_NOP});
        end
        checks++;
        if (resp_data !== 8'hA5 || resp_id !== 1'b1) begin
            errors++;
            $display("FAIL pass_result: data=%h id=%b required A5 id 1", resp_data, resp_id);
        end
        step();
    endtask

    task automatic test_back_to_back;
        int n;
        logic [1:0] exp_rdy;
        logic [7:0] exp_data;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_cmd[0] = CMD_ADD; req_a[0] = 8'h10; req_b[0] = 8'h01;
        req_cmd[1] = CMD_ADD; req_a[1] = 8'h20; req_b[1] = 8'h02;
        req_valid  = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (k % 2 == 0) ? 8'h11 : 8'h22;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin step(); n++; end
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant[%0d]: req_ready=%b required %b", k, req_ready, exp_rdy);
            end
            step();
            n = 0;
            while (!resp_valid && n < 10) begin step(); n++; end
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== exp_rdy[1] || resp_data !== exp_data) begin
                errors++;
                $display("FAIL rr_resp[%0d]: rv=%b id=%b data=%h required 1 %b %h",
                         k, resp_valid, resp_id, resp_data, exp_rdy[1], exp_data);
            end
            step();
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_backpressure;
        int lat;
        logic [17:0] seq;
        int bad;
        resp_ready = 1'b0;
        do_cmd(0, CMD_PASS, 8'h3C, 8'h00, lat, seq);
        req_valid[1] = 1'b1;
        req_cmd[1]   = CMD_ADD;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (resp_valid !== 1'b1 || resp_data !== 8'h3C || busy !== 1'b1 || req_ready !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad cycles, last rv=%b data=%h busy=%b rdy=%b required 1 3C 1 00",
                     bad, resp_valid, resp_data, busy, req_ready);
        end
        req_valid[1] = 1'b0;
        resp_ready   = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: busy=%b rv=%b required 0 0", busy, resp_valid);
        end
    endtask

    task automatic test_reset_abort;
        int n;
        int bad;
        req_cmd[1] = CMD_ADD; req_a[1] = 8'h44; req_b[1] = 8'h11;
        req_valid[1] = 1'b1;
        n = 0;
        while (alu_op !== ALU_ADD && n < 20) begin
            step();
            if (busy) req_valid[1] = 1'b0;
            n++;
        end
        req_valid[1] = 1'b0;
        checks++;
        if (alu_op !== ALU_ADD) begin
            errors++;
            $display("FAIL abort_reach_exec: alu_op=%0d required %0d", alu_op, ALU_ADD);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || alu_op !== ALU_NOP || resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b op=%0d rv=%b data=%h id=%b required 0 0 0 00 0",
                     busy, alu_op, resp_valid, resp_data, resp_id);
        end
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (resp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_resp: %0d cycles with activity, required 0", bad);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL abort_first_grant: req_ready=%b required 01", req_ready);
        end
        req_valid = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_inc_pass();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
